// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM state type for the SPI register controller.
package spi_reg_pkg;

  localparam int FRAME_BITS = 16;
  localparam int REG_W      = 8;
  localparam int NUM_REGS   = 5;
  localparam int CNT_W      = 5;

  localparam int ADDR_EN_OUT_LO = 0;
  localparam int ADDR_EN_OUT_HI = 1;
  localparam int ADDR_EN_PWM_LO = 2;
  localparam int ADDR_EN_PWM_HI = 3;
  localparam int ADDR_DUTY      = 4;

  // Bit count saturates here so over-long frames can never look complete.
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_reg_ctrl_sync_edge.sv
// Multi-flop input synchroniser with a history flop for rise/fall pulses.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES:0] chain_q, chain_d;

  always_comb chain_d = {chain_q[STAGES-1:0], d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_q <= {(STAGES+1){RESET_VAL}};
    else        chain_q <= chain_d;
  end

  assign level = chain_q[STAGES-1];
  assign rise  =  chain_q[STAGES-1] & ~chain_q[STAGES];
  assign fall  = ~chain_q[STAGES-1] &  chain_q[STAGES];

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI-slave write path into five 8-bit PWM control registers.
// Optional read-back on cipo is built only when SPI_READBACK_EN is defined.
//
// state    | meaning
// ST_IDLE  | ncs high, waiting for a synchronised ncs falling edge
// ST_SHIFT | frame in progress, shifting copi on each sclk rise
// ST_CHECK | one cycle after ncs rise, validate frame and commit
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             copi,
  input  logic             ncs,
  output logic [REG_W-1:0] en_reg_out_7_0,
  output logic [REG_W-1:0] en_reg_out_15_8,
  output logic [REG_W-1:0] en_reg_pwm_7_0,
  output logic [REG_W-1:0] en_reg_pwm_15_8,
  output logic [REG_W-1:0] pwm_duty_cycle,
  output logic             commit
`ifdef SPI_READBACK_EN
  ,
  output logic             cipo
`endif
);

  logic sclk_s, sclk_rise, sclk_fall;
  logic copi_s, copi_rise, copi_fall;
  logic ncs_s, ncs_rise, ncs_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d(copi), .level(copi_s), .rise(copi_rise), .fall(copi_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d(ncs), .level(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
  );

  spi_state_t                       state_q, state_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]            shift_q, shift_d;
  logic [NUM_REGS-1:0][REG_W-1:0]   regs_q, regs_d;
  logic                             commit_q, commit_d;
  logic [6:0]                       addr;
  logic                             frame_ok;

  assign addr     = shift_q[14:8];
  assign frame_ok = (cnt_q == CNT_FULL) && shift_q[15] && (addr <= MAX_ADDR);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    regs_d   = regs_q;
    commit_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ncs_fall) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      ST_SHIFT: begin
        if (sclk_rise && !ncs_s) begin
          shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
          if (cnt_q != CNT_OVF) cnt_d = cnt_q + CNT_W'(1);
        end
        if (ncs_rise) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (frame_ok) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == 7'(i)) regs_d[i] = shift_q[REG_W-1:0];
          end
          commit_d = 1'b1;
        end
        // A new frame starting right away must not wait for IDLE to see the edge.
        if (ncs_fall) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      regs_q   <= '0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      regs_q   <= regs_d;
      commit_q <= commit_d;
    end
  end

  assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO];
  assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI];
  assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO];
  assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI];
  assign pwm_duty_cycle  = regs_q[ADDR_DUTY];
  assign commit          = commit_q;

`ifdef SPI_READBACK_EN
  logic [REG_W-1:0] sout_q, sout_d;
  logic [6:0]       rd_addr;
  logic [REG_W-1:0] rd_data;
  logic             unused_edges;

  assign unused_edges = copi_rise | copi_fall | sclk_s;
  // Address is complete on the 8th rise: six bits already shifted plus the live copi bit.
  assign rd_addr = {shift_q[5:0], copi_s};

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == 7'(i) && rd_addr <= MAX_ADDR) rd_data = regs_q[i];
    end
  end

  always_comb begin
    sout_d = sout_q;
    if (ncs_s)
      sout_d = '0;
    else if (state_q == ST_SHIFT && sclk_rise && cnt_q == CNT_W'(7) && !shift_q[6])
      sout_d = rd_data;
    else if (sclk_fall)
      sout_d = {sout_q[REG_W-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sout_q <= '0;
    else        sout_q <= sout_d;
  end

  assign cipo = sout_q[REG_W-1];
`else
  logic unused_edges;
  assign unused_edges = copi_rise | copi_fall | sclk_fall | sclk_s;
`endif

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: frames push expected commits, a monitor logs observed ones.
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, sclk, copi, ncs;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       commit;
`ifdef SPI_READBACK_EN
  logic       cipo;
`endif

  spi_reg_ctrl dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .commit(commit)
`ifdef SPI_READBACK_EN
    , .cipo(cipo)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  lat;
    logic [39:0] regs;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         obs_q[$];
  logic [39:0] model;
  logic [15:0] last_rx;
  int          tests = 0;
  int          fails = 0;
  int          since_rise = 0;
  logic        ncs_prev = 1'b1;
  logic [39:0] cur_regs;

  assign cur_regs = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};

  // Edge 1 is the first clk edge that samples ncs high.
  always @(posedge clk) begin
    ncs_prev <= ncs;
    if (ncs && !ncs_prev) since_rise <= 1;
    else                  since_rise <= since_rise + 1;
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && commit === 1'b1) obs_q.push_back('{lat: since_rise[7:0], regs: cur_regs});
  end

  task automatic shift_bits(input logic [31:0] v, input int n, output logic [15:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      copi = v[n-1-i];
      sclk = 1'b0;
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
`ifdef SPI_READBACK_EN
      if (i < 16) rx[15-i] = cipo;
`endif
    end
  endtask

  task automatic send_frame(input logic [31:0] v, input int n, input int gap);
    logic [15:0] rx;
    int          a;
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(v, n, rx);
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    ncs = 1'b1;
    a = int'(v[14:8]);
    if (n == 16 && v[15] && a <= 4) begin
      model[a*8 +: 8] = v[7:0];
      exp_q.push_back('{lat: 8'd4, regs: model});
    end
    last_rx = rx;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    model = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (en_reg_out_7_0 !== 8'h00)  begin fails++; $display("FAIL reset out_lo: got %h want 00", en_reg_out_7_0); end
    tests++; if (en_reg_out_15_8 !== 8'h00) begin fails++; $display("FAIL reset out_hi: got %h want 00", en_reg_out_15_8); end
    tests++; if (en_reg_pwm_7_0 !== 8'h00)  begin fails++; $display("FAIL reset pwm_lo: got %h want 00", en_reg_pwm_7_0); end
    tests++; if (en_reg_pwm_15_8 !== 8'h00) begin fails++; $display("FAIL reset pwm_hi: got %h want 00", en_reg_pwm_15_8); end
    tests++; if (pwm_duty_cycle !== 8'h00)  begin fails++; $display("FAIL reset duty: got %h want 00", pwm_duty_cycle); end
    tests++; if (commit !== 1'b0)           begin fails++; $display("FAIL reset commit: got %b want 0", commit); end
`ifdef SPI_READBACK_EN
    tests++; if (cipo !== 1'b0)             begin fails++; $display("FAIL reset cipo: got %b want 0", cipo); end
`endif
  endtask

  task automatic test_write_all();
    logic [15:0] frames [5] = '{16'h80F0, 16'h810F, 16'h82AA, 16'h8355, 16'h8480};
    ev_t e, o;
    for (int i = 0; i < 5; i++) send_frame({16'h0, frames[i]}, 16, 8);
    repeat (8) @(negedge clk);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL write_all commit count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o.lat !== e.lat)   begin fails++; $display("FAIL write_all latency: got %0d want %0d", o.lat, e.lat); end
      tests++; if (o.regs !== e.regs) begin fails++; $display("FAIL write_all regs: got %h want %h", o.regs, e.regs); end
    end
    exp_q.delete(); obs_q.delete();
    tests++; if (cur_regs !== 40'h80_55_AA_0F_F0) begin fails++; $display("FAIL write_all final: got %h want 8055AA0FF0", cur_regs); end
  endtask

  task automatic test_dropped();
    logic [31:0] vals [5] = '{32'h8A12, 32'h8512, 32'h8042 >> 1, 32'h1_8433, 32'h0077};
    int          lens [5] = '{16, 16, 15, 17, 16};
    // sclk activity while deselected must be ignored.
    for (int k = 0; k < 3; k++) begin
      sclk = 1'b1; repeat (4) @(negedge clk);
      sclk = 1'b0; repeat (4) @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      send_frame(vals[i], lens[i], 8);
      tests++;
      if (cur_regs !== model) begin fails++; $display("FAIL dropped frame %0d regs: got %h want %h", i, cur_regs, model); end
    end
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL dropped commit count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    ev_t e, o;
    send_frame(32'h8001, 16, 4);
    send_frame(32'h8002, 16, 10);
    tests++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin
      fails++; $display("FAIL b2b commit count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o.lat !== e.lat)   begin fails++; $display("FAIL b2b latency: got %0d want %0d", o.lat, e.lat); end
      tests++; if (o.regs !== e.regs) begin fails++; $display("FAIL b2b regs: got %h want %h", o.regs, e.regs); end
    end
    exp_q.delete(); obs_q.delete();
    tests++; if (en_reg_out_7_0 !== 8'h02) begin fails++; $display("FAIL b2b out_lo: got %h want 02", en_reg_out_7_0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] rx;
    ev_t e, o;
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(32'h8477 >> 7, 9, rx);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    model = '0;
    exp_q.delete(); obs_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    tests++; if (cur_regs !== 40'h0) begin fails++; $display("FAIL midreset regs: got %h want 0", cur_regs); end
    tests++; if (commit !== 1'b0)    begin fails++; $display("FAIL midreset commit: got %b want 0", commit); end
    send_frame(32'h8455, 16, 10);
    tests++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      fails++; $display("FAIL midreset commit count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o.regs !== e.regs) begin fails++; $display("FAIL midreset regs after frame: got %h want %h", o.regs, e.regs); end
    end
    exp_q.delete(); obs_q.delete();
    tests++; if (pwm_duty_cycle !== 8'h55) begin fails++; $display("FAIL midreset duty: got %h want 55", pwm_duty_cycle); end
  endtask

`ifdef SPI_READBACK_EN
  task automatic test_readback();
    send_frame(32'h82AA, 16, 8);
    send_frame(32'h0200, 16, 8);
    // Samples taken just before the falls after rises 8..15 carry the byte MSB first.
    tests++; if (last_rx[8:1] !== 8'hAA) begin fails++; $display("FAIL readback cipo: got %h want AA", last_rx[8:1]); end
    tests++; if (cipo !== 1'b0) begin fails++; $display("FAIL readback idle cipo: got %b want 0", cipo); end
    exp_q.delete(); obs_q.delete();
  endtask
`endif

  initial begin
    last_rx = '0;
    test_reset();
    test_write_all();
    test_dropped();
    test_back_to_back();
`ifdef SPI_READBACK_EN
    test_readback();
`endif
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
